exmem_wb_stage: RTL

Pipeline register and write-back stage between the combined execute/memory stage and the register file. Captures the ALU result or the data-memory read word, drives the register-file write port (`WB_data`, `WB_rD`, `WB_ppp`, `WB_wrEn`), and generates the registered `forward_rA`/`forward_rB` flags that the execute stage uses to merge `WB_data` into its operands. Converts execute-stage load stalls into write-back bubbles without losing forwarded data.

---
 rtl/exmem_wb_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/exmem_wb_stage.sv
// Execute/memory -> write-back pipeline register: drives the register-file write port and the
// registered forwarding flags. Optional performance counters are built when WB_PERF_CNT_EN is defined.
module exmem_wb_stage #(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:DATA_W-1]  exmem_alu_out,
    input  logic [0:DATA_W-1]  dmem_dout,
    input  logic [RADDR_W-1:0] exmem_rD,
    input  logic [2:0]         exmem_ppp,
    input  logic               exmem_wrEn,
    input  logic               exmem_valid,
    input  logic               exmem_rD_data_select,
    input  logic               exmem_stall,
    input  logic [RADDR_W-1:0] idex_rA,
    input  logic [RADDR_W-1:0] idex_rB,
    output logic [0:DATA_W-1]  WB_data,
    output logic [RADDR_W-1:0] WB_rD,
    output logic [2:0]         WB_ppp,
    output logic               WB_wrEn,
    output logic               forward_rA,
    output logic               forward_rB
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    logic               capture;
    logic               commit;
    logic [0:DATA_W-1]  data_next;
    logic [0:DATA_W-1]  data_reg;
    logic [RADDR_W-1:0] rd_reg;
    logic [2:0]         ppp_reg;
    logic               wren_reg;
    logic [1:0]         fwd_next;
    logic [1:0]         fwd_reg;
    logic [RADDR_W-1:0] src_addr [2];

    assign capture   = !exmem_stall;
    assign commit    = capture && exmem_valid && exmem_wrEn;
    assign data_next = exmem_rD_data_select ? dmem_dout : exmem_alu_out;

    assign src_addr[0] = idex_rA;
    assign src_addr[1] = idex_rB;

    // One match comparator per execute-stage source operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_next[gi] = commit && (exmem_rD == src_addr[gi]);
        end
    endgenerate

    // A stall holds everything except the strobe, which drops so the last write is not repeated;
    // the held forward flags keep the stalled instruction seeing the same merged value.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
            rd_reg   <= '0;
            ppp_reg  <= 3'b000;
            wren_reg <= 1'b0;
            fwd_reg  <= 2'b00;
        end else if (capture) begin
            data_reg <= data_next;
            rd_reg   <= exmem_rD;
            ppp_reg  <= exmem_ppp;
            wren_reg <= commit;
            fwd_reg  <= fwd_next;
        end else begin
            wren_reg <= 1'b0;
        end
    end

    assign WB_data    = data_reg;
    assign WB_rD      = rd_reg;
    assign WB_ppp     = ppp_reg;
    assign WB_wrEn    = wren_reg;
    assign forward_rA = fwd_reg[0];
    assign forward_rB = fwd_reg[1];

`ifdef WB_PERF_CNT_EN
    logic [31:0] retired_reg;
    logic [31:0] bubble_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_reg <= '0;
            bubble_reg  <= '0;
        end else begin
            if (capture && exmem_valid)
                retired_reg <= retired_reg + 32'd1;
            if (exmem_stall || !exmem_valid)
                bubble_reg <= bubble_reg + 32'd1;
        end
    end

    assign retired_cnt = retired_reg;
    assign bubble_cnt  = bubble_reg;
`endif

endmodule
